// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - shared types and helpers for the credit-limited dependent-read chain
package credit_pkg;

    // Bit positions inside the internal error flag vector
    localparam int ERR_MID_OVF = 0;
    localparam int ERR_OUT_OVF = 1;
    localparam int ERR_W       = 2;

    // RAM1 issue engine states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } eng_state_t;

    // Width needed to hold a count from 0 up to n inclusive
    function automatic int clog2_cnt(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cr_sync_fifo.sv
// rtl/cr_sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-2 depth
module cr_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is dropped; the owner flags it as an error
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == NW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + NW'(do_wr) - NW'(do_rd);
        end
    end

    // Storage array, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/credit_ram_chain.sv
// rtl/credit_ram_chain.sv - two-stage dependent RAM read pipeline with credit flow control
module credit_ram_chain
    import credit_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int CREDITS    = 16,
    parameter int TLAST_LEN  = 0,
    parameter int RESP_GUARD = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDR_W-1:0]               s_addr_tdata,
    input  logic                            s_addr_tvalid,
    output logic                            s_addr_tready,
    output logic [ADDR_W-1:0]               ram0_addr,
    output logic                            ram0_read,
    input  logic [DATA_W-1:0]               ram0_data,
    input  logic                            ram0_valid,
    output logic [ADDR_W-1:0]               ram1_addr,
    output logic                            ram1_read,
    input  logic [DATA_W-1:0]               ram1_data,
    input  logic                            ram1_valid,
    output logic [DATA_W-1:0]               m_data_tdata,
    output logic                            m_data_tvalid,
    input  logic                            m_data_tready,
    output logic                            m_data_tlast,
    output logic [clog2_cnt(CREDITS)-1:0]   credit_cnt,
    output logic                            err_overflow
);

    localparam int CW = clog2_cnt(CREDITS);
    localparam int GW = (RESP_GUARD > 0) ? $clog2(RESP_GUARD + 1) : 1;
    localparam int BW = (TLAST_LEN > 1) ? $clog2(TLAST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = (TLAST_LEN > 0) ? BW'(TLAST_LEN - 1) : '0;

    logic              accept;
    logic              pop;
    logic              resp_ok;
    logic [GW-1:0]     guard_cnt;
    logic [BW-1:0]     beat_cnt;
    logic [ERR_W-1:0]  err_flags;
    eng_state_t        state;

    logic [DATA_W-1:0] mid_head;
    logic              mid_full;
    logic              mid_empty;
    logic              mid_rd;
    logic [CW-1:0]     mid_count;
    logic [DATA_W-1:0] out_head;
    logic              out_full;
    logic              out_empty;
    logic [CW-1:0]     out_count;
    logic              mid_head_unused;

    // Address side: a free credit is the only condition for accepting an address
    assign s_addr_tready = (credit_cnt != '0);
    assign accept        = s_addr_tvalid && s_addr_tready;
    assign ram0_read     = accept;
    assign ram0_addr     = s_addr_tdata;

    // Output side
    assign m_data_tvalid = !out_empty;
    assign m_data_tdata  = out_head;
    assign pop           = m_data_tvalid && m_data_tready;
    assign m_data_tlast  = (TLAST_LEN > 0) && m_data_tvalid && (beat_cnt == BEAT_LAST);
    assign err_overflow  = |err_flags;

    // Engine drains the mid FIFO one entry per cycle whenever it holds data
    assign mid_rd          = !mid_empty;
    assign ram1_read       = (state == ISSUE);
    assign resp_ok         = (guard_cnt == '0);
    assign mid_head_unused = ^(mid_head >> ADDR_W);

    cr_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (CREDITS)
    ) u_mid_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ram0_valid && resp_ok),
        .wr_data (ram0_data),
        .rd_en   (mid_rd),
        .rd_data (mid_head),
        .full    (mid_full),
        .empty   (mid_empty),
        .count   (mid_count)
    );

    cr_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (CREDITS)
    ) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ram1_valid && resp_ok),
        .wr_data (ram1_data),
        .rd_en   (pop),
        .rd_data (out_head),
        .full    (out_full),
        .empty   (out_empty),
        .count   (out_count)
    );

    // Blind window after reset so stale RAM responses from before reset are discarded
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            guard_cnt <= GW'(RESP_GUARD);
        end else if (guard_cnt != '0) begin
            guard_cnt <= guard_cnt - GW'(1);
        end
    end

    // Credits: one consumed per accepted address, one returned per delivered beat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            credit_cnt <= CW'(CREDITS);
        end else begin
            credit_cnt <= credit_cnt - CW'(accept) + CW'(pop);
        end
    end

    // RAM1 issue engine: registered read strobe and address from the mid FIFO head
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ram1_addr <= '0;
        end else if (mid_rd) begin
            state     <= ISSUE;
            ram1_addr <= mid_head[ADDR_W-1:0];
        end else begin
            state     <= IDLE;
        end
    end

    // Packet beat counter for tlast generation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BW'(1);
        end
    end

    // Sticky overflow flags, only reachable when a RAM answers without a matching read
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_flags <= '0;
        end else begin
            if (resp_ok && ram0_valid && mid_full) err_flags[ERR_MID_OVF] <= 1'b1;
            if (resp_ok && ram1_valid && out_full) err_flags[ERR_OUT_OVF] <= 1'b1;
        end
    end

    // Structural invariants of the credit scheme
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (credit_cnt <= CW'(CREDITS));
            assert (!(pop && out_empty));
            assert (!(mid_rd && mid_empty));
            assert (int'(mid_count) + int'(out_count) <= CREDITS - int'(credit_cnt));
        end
    end

endmodule

// File: tb/tb_credit_ram_chain.sv
// tb/tb_credit_ram_chain.sv - randomized and directed bench with a queue-based reference model
module tb_credit_ram_chain;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int CREDITS    = 4;
    localparam int TLAST_LEN  = 3;
    localparam int RESP_GUARD = 4;
    localparam int CW         = $clog2(CREDITS + 1);

    bit                 clk = 1'b0;
    logic               reset_n;
    logic [ADDR_W-1:0]  s_addr_tdata;
    logic               s_addr_tvalid;
    logic               s_addr_tready;
    logic [ADDR_W-1:0]  ram0_addr;
    logic               ram0_read;
    logic [DATA_W-1:0]  ram0_data;
    logic               ram0_valid;
    logic [ADDR_W-1:0]  ram1_addr;
    logic               ram1_read;
    logic [DATA_W-1:0]  ram1_data;
    logic               ram1_valid;
    logic [DATA_W-1:0]  m_data_tdata;
    logic               m_data_tvalid;
    logic               m_data_tready;
    logic               m_data_tlast;
    logic [CW-1:0]      credit_cnt;
    logic               err_overflow;

    logic [DATA_W-1:0]  mem0 [256];
    logic [DATA_W-1:0]  mem1 [256];
    bit                 r0_v, r1_v;
    logic [DATA_W-1:0]  r0_d, r1_d;
    logic               inj0, inj1;
    logic [DATA_W-1:0]  inj_data;
    logic               exp_err;

    int                 n_vec  = 0;
    int                 n_fail = 0;
    int                 n_acc  = 0;
    int                 beat   = 0;
    logic [DATA_W-1:0]  q [$];
    bit                 last_q [$];

    credit_ram_chain #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CREDITS    (CREDITS),
        .TLAST_LEN  (TLAST_LEN),
        .RESP_GUARD (RESP_GUARD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_addr_tdata  (s_addr_tdata),
        .s_addr_tvalid (s_addr_tvalid),
        .s_addr_tready (s_addr_tready),
        .ram0_addr     (ram0_addr),
        .ram0_read     (ram0_read),
        .ram0_data     (ram0_data),
        .ram0_valid    (ram0_valid),
        .ram1_addr     (ram1_addr),
        .ram1_read     (ram1_read),
        .ram1_data     (ram1_data),
        .ram1_valid    (ram1_valid),
        .m_data_tdata  (m_data_tdata),
        .m_data_tvalid (m_data_tvalid),
        .m_data_tready (m_data_tready),
        .m_data_tlast  (m_data_tlast),
        .credit_cnt    (credit_cnt),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    // Single-cycle latency RAM models plus injection of spurious responses
    always @(posedge clk) begin
        r0_v <= ram0_read;
        r0_d <= mem0[ram0_addr];
        r1_v <= ram1_read;
        r1_d <= mem1[ram1_addr];
    end
    assign ram0_valid = r0_v | inj0;
    assign ram0_data  = inj0 ? inj_data : r0_d;
    assign ram1_valid = r1_v | inj1;
    assign ram1_data  = inj1 ? inj_data : r1_d;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding transactions in a queue, credits = CREDITS - outstanding
    always @(negedge clk) begin
        bit                acc;
        logic [ADDR_W-1:0] a1;
        if (!reset_n) begin
            q.delete();
            beat = 0;
        end else begin
            acc = s_addr_tvalid && (q.size() < CREDITS);
            chk("credit_cnt", credit_cnt, CREDITS - q.size());
            chk("s_addr_tready", s_addr_tready, q.size() < CREDITS);
            chk("ram0_read", ram0_read, acc);
            if (acc) chk("ram0_addr", ram0_addr, s_addr_tdata);
            chk("err_overflow", err_overflow, exp_err);
            if (m_data_tvalid) begin
                if (q.size() == 0) begin
                    chk("tvalid_no_txn", m_data_tvalid, 0);
                end else begin
                    chk("tdata", m_data_tdata, q[0]);
                    chk("tlast", m_data_tlast, beat == TLAST_LEN - 1);
                end
            end
            if (m_data_tvalid && m_data_tready && q.size() > 0) begin
                last_q.push_back(m_data_tlast);
                void'(q.pop_front());
                beat = (beat + 1) % TLAST_LEN;
            end
            if (acc) begin
                a1 = mem0[s_addr_tdata][ADDR_W-1:0];
                q.push_back(mem1[a1]);
                n_acc++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n       = 1'b0;
        s_addr_tvalid = 1'b0;
        exp_err       = 1'b0;
        step(n);
        reset_n       = 1'b1;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a);
        int n;
        s_addr_tdata  = a;
        s_addr_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_addr_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", n >= 200, 0);
        step(1);
        s_addr_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        m_data_tready = 1'b1;
        n = 0;
        @(negedge clk);
        while ((credit_cnt != CW'(CREDITS) || m_data_tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n >= 300, 0);
        step(1);
    endtask

    function automatic int last_bits(input int base, input int len);
        int b = 0;
        for (int i = 0; i < len; i++) begin
            if (base + i < last_q.size()) b |= int'(last_q[base + i]) << i;
        end
        return b;
    endfunction

    initial begin
        int k, a0, p0, base;
        reset_n = 1'b0; s_addr_tvalid = 1'b0; s_addr_tdata = '0; m_data_tready = 1'b0;
        inj0 = 1'b0; inj1 = 1'b0; inj_data = '0; exp_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = DATA_W'($urandom);
            mem1[i] = DATA_W'($urandom);
        end

        // Reset state
        step(3);
        chk("rst_credit", credit_cnt, CREDITS);
        chk("rst_tready", s_addr_tready, 1);
        chk("rst_ram1_read", ram1_read, 0);
        chk("rst_ram1_addr", ram1_addr, 0);
        chk("rst_tvalid", m_data_tvalid, 0);
        chk("rst_tlast", m_data_tlast, 0);
        chk("rst_err", err_overflow, 0);
        reset_n = 1'b1;
        step(6);

        // 1: first-beat latency, then a burst of 7 more, all in order
        m_data_tready = 1'b1;
        p0 = last_q.size();
        s_addr_tdata = ADDR_W'($urandom); s_addr_tvalid = 1'b1;
        step(1);
        s_addr_tvalid = 1'b0;
        k = 1;
        while (!m_data_tvalid && k < 20) begin step(1); k++; end
        chk("first_latency", k, 5);
        for (int i = 0; i < 7; i++) send(ADDR_W'($urandom));
        drain();
        chk("t1_beats", last_q.size() - p0, 8);
        chk("t1_credit", credit_cnt, CREDITS);

        // 2: full backpressure, then a single-beat release
        m_data_tready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            s_addr_tvalid = 1'b1; s_addr_tdata = ADDR_W'($urandom);
            step(1);
        end
        chk("t2_accepted", n_acc - a0, 4);
        chk("t2_credit", credit_cnt, 0);
        chk("t2_tready", s_addr_tready, 0);
        chk("t2_err", err_overflow, 0);
        a0 = n_acc;
        m_data_tready = 1'b1;
        step(1);
        m_data_tready = 1'b0;
        step(5);
        s_addr_tvalid = 1'b0;
        chk("t2_one_more", n_acc - a0, 1);
        drain();

        // 3: simultaneous accept and pop at credit 2, then continuous flow
        m_data_tready = 1'b0;
        send(ADDR_W'($urandom));
        send(ADDR_W'($urandom));
        step(8);
        chk("t3_credit_pre", credit_cnt, 2);
        a0 = n_acc; p0 = last_q.size();
        s_addr_tvalid = 1'b1; s_addr_tdata = ADDR_W'($urandom); m_data_tready = 1'b1;
        step(1);
        s_addr_tvalid = 1'b0; m_data_tready = 1'b0;
        chk("t3_acc", n_acc - a0, 1);
        chk("t3_pop", last_q.size() - p0, 1);
        chk("t3_credit_post", credit_cnt, 2);
        m_data_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_addr_tvalid = 1'b1; s_addr_tdata = ADDR_W'($urandom);
            step(1);
        end
        s_addr_tvalid = 1'b0;
        drain();

        // 4: tlast every third beat, counter cleared by reset
        do_reset(2);
        step(6);
        m_data_tready = 1'b1;
        base = last_q.size();
        for (int i = 0; i < 7; i++) send(ADDR_W'($urandom));
        drain();
        chk("t4_beats7", last_q.size() - base, 7);
        chk("t4_tlast7", last_bits(base, 7), 36);
        do_reset(2);
        step(6);
        base = last_q.size();
        for (int i = 0; i < 3; i++) send(ADDR_W'($urandom));
        drain();
        chk("t4_beats3", last_q.size() - base, 3);
        chk("t4_tlast3", last_bits(base, 3), 4);

        // 5: reset with transactions in flight, late responses inside the guard window
        m_data_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(ADDR_W'($urandom));
        do_reset(2);
        step(1);
        inj0 = 1'b1; inj1 = 1'b1; inj_data = DATA_W'($urandom);
        step(2);
        inj0 = 1'b0; inj1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t5_tvalid", m_data_tvalid, 0);
            chk("t5_ram1_read", ram1_read, 0);
            chk("t5_credit", credit_cnt, CREDITS);
            step(1);
        end

        // 6: spurious RAM1 response into a full output FIFO
        m_data_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(ADDR_W'($urandom));
        step(10);
        chk("t6_credit", credit_cnt, 0);
        chk("t6_tvalid", m_data_tvalid, 1);
        inj1 = 1'b1; inj_data = DATA_W'($urandom);
        step(1);
        inj1 = 1'b0;
        exp_err = 1'b1;
        step(5);
        chk("t6_err_held", err_overflow, 1);
        do_reset(2);
        step(6);
        chk("t6_err_cleared", err_overflow, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s_addr_tvalid = 1'($urandom_range(0, 1));
            s_addr_tdata  = ADDR_W'($urandom);
            m_data_tready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        s_addr_tvalid = 1'b0;
        drain();
        chk("end_credit", credit_cnt, CREDITS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
